data_memory_sized: RTL

Parametrised successor to the single-cycle data memory: a word-organised RAM with byte/halfword/word loads and stores, sign/zero extension, alignment and range checking, and a valid/ready request port with a configurable fixed access latency. Sits between the CPU's load/store stage and storage, so the multi-cycle and pipelined cores can stall on memory instead of assuming a combinational read.

---
 rtl/data_memory_sized.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/data_memory_sized.sv
// data_memory_sized: word-organised RAM with byte/half/word loads and stores,
// sign/zero extension, alignment/range checking and a valid/ready request port
// with a fixed, parameterised access latency.
module data_memory_sized #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;

  logic        cap_write;
  logic [1:0]  cap_size;
  logic        cap_unsigned;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        commit;
  logic        use_live;

  // effective request at the commit edge: live inputs when LATENCY==0
  // commits on the accept edge itself, captured fields otherwise
  logic        c_write;
  logic [1:0]  c_size;
  logic        c_unsigned;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;

  logic                  err;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           word;
  logic [31:0]           byte_shift;
  logic [31:0]           half_shift;
  logic [31:0]           load_val;
  logic [3:0]            lane_mask;
  logic [31:0]           lane_data;
  logic [31:0]           merged;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign use_live  = (state == IDLE);
  assign commit    = (use_live && accept && (LATENCY == 0)) ||
                     ((state == WAIT) && (cnt == 4'd1));

  assign c_write    = use_live ? req_write    : cap_write;
  assign c_size     = use_live ? req_size     : cap_size;
  assign c_unsigned = use_live ? req_unsigned : cap_unsigned;
  assign c_addr     = use_live ? req_addr     : cap_addr;
  assign c_wdata    = use_live ? req_wdata    : cap_wdata;

  assign idx        = c_addr[ADDR_WIDTH+1:2];
  assign word       = mem[idx];
  assign byte_shift = word >> {c_addr[1:0], 3'b000};
  assign half_shift = word >> {c_addr[1], 4'b0000};

  // error classification of the committing request
  always_comb begin
    err = 1'b0;
    if (c_size == 2'b11)                          err = 1'b1;
    if ((c_size == 2'b01) && c_addr[0])           err = 1'b1;
    if ((c_size == 2'b10) && (c_addr[1:0] != 0))  err = 1'b1;
    if ((c_addr >> (ADDR_WIDTH + 2)) != 32'd0)    err = 1'b1;
  end

  // lane extraction and sign/zero extension for loads
  always_comb begin
    load_val = word;
    case (c_size)
      2'b00:   load_val = c_unsigned ? {24'd0, byte_shift[7:0]}
                                     : {{24{byte_shift[7]}}, byte_shift[7:0]};
      2'b01:   load_val = c_unsigned ? {16'd0, half_shift[15:0]}
                                     : {{16{half_shift[15]}}, half_shift[15:0]};
      default: load_val = word;
    endcase
  end

  // byte-lane enables and replicated store data, merged over the old word
  always_comb begin
    lane_mask = 4'b1111;
    lane_data = c_wdata;
    case (c_size)
      2'b00: begin
        lane_mask = 4'b0001 << c_addr[1:0];
        lane_data = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = 4'b0011 << {c_addr[1], 1'b0};
        lane_data = {2{c_wdata[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = c_wdata;
      end
    endcase
    merged = word;
    for (int i = 0; i < 4; i++)
      if (lane_mask[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
  end

  // control FSM, request capture and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_err     <= 1'b0;
      cap_write    <= 1'b0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_addr     <= 32'd0;
      cap_wdata    <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cap_write    <= req_write;
          cap_size     <= req_size;
          cap_unsigned <= req_unsigned;
          cap_addr     <= req_addr;
          cap_wdata    <= req_wdata;
          cnt          <= 4'(LATENCY);
          state        <= (LATENCY == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= err;
        resp_rdata <= (err || c_write) ? 32'd0 : load_val;
      end
    end
  end

  // storage write on the commit edge; reset on that edge suppresses it
  always_ff @(posedge clk) begin
    if (!reset && commit && c_write && !err)
      mem[idx] <= merged;
  end

endmodule
